// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among eight requesters.
// It drives a Valid/Ack handshake toward the consumer and aborts stalled transfers with a watchdog.

module mux8to1 (
  input  logic [0:7] w_i,
  input  logic [2:0] s_i,
  output logic       f_o
);

  // Pure combinational select of one data bit
  always_comb begin
    f_o = w_i[s_i];
  end

endmodule

module mux8_rr_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [0:7] R,
  input  logic [0:7] W,
  input  logic       Ack,
  output logic [0:7] G,
  output logic [2:0] S,
  output logic       f,
  output logic       Valid,
  output logic       Err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  localparam bit         WDOG_EN  = (TIMEOUT != 0);
  localparam logic [7:0] CNT_LAST = WDOG_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] cnt_q;
  logic [2:0] pick_s;
  logic       mux_f_s;

  // First set request scanning upward from ptr, wrapping modulo 8
  function automatic logic [2:0] rr_pick(input logic [0:7] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] cand;
    logic       found;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [0:7] onehot(input logic [2:0] idx);
    logic [0:7] v;
    v      = 8'h00;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Arbitration winner for the current request vector
  always_comb begin
    pick_s = rr_pick(R, ptr_q);
  end

  mux8to1 u_mux (
    .w_i (W),
    .s_i (S),
    .f_o (mux_f_s)
  );

  // Scheduler FSM with registered grant, select, data, handshake and error pulse
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 8'd0;
      S       <= 3'd0;
      G       <= 8'h00;
      f       <= 1'b0;
      Valid   <= 1'b0;
      Err     <= 1'b0;
    end else begin
      Err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|R) begin
            S       <= pick_s;
            G       <= onehot(pick_s);
            state_q <= ST_SAMPLE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SAMPLE: begin
          f       <= mux_f_s;
          Valid   <= 1'b1;
          cnt_q   <= 8'd0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Ack has priority over a simultaneous timeout
          if (Ack) begin
            Valid   <= 1'b0;
            G       <= 8'h00;
            ptr_q   <= S + 3'd1;
            state_q <= ST_IDLE;
          end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
            Valid   <= 1'b0;
            G       <= 8'h00;
            Err     <= 1'b1;
            ptr_q   <= S + 3'd1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          Valid   <= 1'b0;
          G       <= 8'h00;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched: directed scenarios plus random traffic
// compared against a transfer-age reference model.

module tb_mux8_rr_sched;

  localparam int TO = 3;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [0:7] R;
  logic [0:7] W;
  logic       Ack;
  logic [0:7] G;
  logic [2:0] S;
  logic       f;
  logic       Valid;
  logic       Err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: is a transfer in flight, who owns it, and how many edges since grant
  bit         m_busy;
  int         m_idx;
  int         m_age;
  int         m_ptr;
  logic [2:0] m_s;
  logic       m_f;
  logic       m_err;

  mux8_rr_sched #(.TIMEOUT(TO)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .R     (R),
    .W     (W),
    .Ack   (Ack),
    .G     (G),
    .S     (S),
    .f     (f),
    .Valid (Valid),
    .Err   (Err)
  );

  always #5 Clock = ~Clock;

  function automatic logic [0:7] oh(input int i);
    logic [0:7] v;
    v    = 8'h00;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    m_busy = 1'b0;
    m_idx  = 0;
    m_age  = 0;
    m_ptr  = 0;
    m_s    = 3'd0;
    m_f    = 1'b0;
    m_err  = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied
  task automatic m_edge();
    bit found;
    m_err = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && R[(m_ptr + k) % 8]) begin
          found = 1'b1;
          m_idx = (m_ptr + k) % 8;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_s    = 3'(m_idx);
      end
    end else if (m_age == 0) begin
      m_f   = W[m_idx];
      m_age = 1;
    end else if (Ack) begin
      m_busy = 1'b0;
      m_ptr  = (m_idx + 1) % 8;
    end else if (TO != 0 && m_age == TO) begin
      m_busy = 1'b0;
      m_ptr  = (m_idx + 1) % 8;
      m_err  = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  task automatic chk_all();
    chk("G", G, m_busy ? oh(m_idx) : 8'h00);
    chk("S", 8'(S), 8'(m_s));
    chk("f", 8'(f), 8'(m_f));
    chk("Valid", 8'(Valid), 8'(m_busy && m_age >= 1));
    chk("Err", 8'(Err), 8'(m_err));
  endtask

  task automatic step(input logic [0:7] r, input logic [0:7] w, input logic a);
    R   = r;
    W   = w;
    Ack = a;
    m_edge();
    @(posedge Clock);
    #1;
    chk_all();
  endtask

  initial begin
    int vcnt;
    int ecnt;
    logic [0:7] rr;

    Resetn = 1'b0;
    R      = 8'h00;
    W      = 8'h00;
    Ack    = 1'b0;
    m_reset();
    repeat (2) @(posedge Clock);
    #1;
    chk_all();
    Resetn = 1'b1;

    // Rotation from pointer 0 with alternating data
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 8'b10101010, 1'b1);
      chk("rot_s", 8'(S), 8'(i % 8));
      step(8'hFF, 8'b10101010, 1'b1);
      chk("rot_f", 8'(f), (i % 2 == 0) ? 8'd1 : 8'd0);
      step(8'hFF, 8'b10101010, 1'b1);
      chk("rot_idle_v", 8'(Valid), 8'd0);
    end

    // Single requester 5
    step(8'b00000100, 8'b00000100, 1'b1);
    chk("single_s", 8'(S), 8'd5);
    chk("single_g", G, 8'b00000100);
    step(8'b00000100, 8'b00000100, 1'b1);
    chk("single_v", 8'(Valid), 8'd1);
    chk("single_f", 8'(f), 8'd1);
    step(8'b00000000, 8'b00000100, 1'b1);
    chk("single_done_g", G, 8'h00);

    // Pointer skip: 6 completes, then 2 and 7 compete
    step(8'b00000010, 8'h00, 1'b1);
    chk("skip6_s", 8'(S), 8'd6);
    step(8'b00000000, 8'h00, 1'b1);
    step(8'b00000000, 8'h00, 1'b1);
    step(8'b00100001, 8'h00, 1'b1);
    chk("skip_first", 8'(S), 8'd7);
    step(8'b00100001, 8'h00, 1'b1);
    step(8'b00100001, 8'h00, 1'b1);
    step(8'b00100001, 8'h00, 1'b1);
    chk("skip_second", 8'(S), 8'd2);
    step(8'b00000000, 8'h00, 1'b1);
    step(8'b00000000, 8'h00, 1'b1);

    // Watchdog on requester 1
    step(8'b01000000, 8'hFF, 1'b0);
    chk("wd_s", 8'(S), 8'd1);
    vcnt = 0;
    ecnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 8'hFF, 1'b0);
      vcnt += int'(Valid);
      ecnt += int'(Err);
    end
    chk("wd_valid_cycles", 8'(vcnt), 8'(TO));
    chk("wd_err_cycles", 8'(ecnt), 8'd1);
    for (int i = 0; i < 8; i++) begin
      step(8'hFF, 8'h00, 1'b1);
      chk("wd_fair_order", 8'(S), 8'((2 + i) % 8));
      step(8'hFF, 8'h00, 1'b1);
      step(8'hFF, 8'h00, 1'b1);
    end

    // Ack coincides with the timeout edge
    step(8'b00001000, 8'hFF, 1'b0);
    chk("coll_s", 8'(S), 8'd4);
    step(8'b00000000, 8'hFF, 1'b0);
    step(8'b00000000, 8'hFF, 1'b0);
    step(8'b00000000, 8'hFF, 1'b0);
    step(8'b00000000, 8'hFF, 1'b1);
    chk("coll_err", 8'(Err), 8'd0);
    chk("coll_valid", 8'(Valid), 8'd0);
    step(8'b00000000, 8'hFF, 1'b0);
    chk("coll_err_late", 8'(Err), 8'd0);

    // Asynchronous reset mid-WAIT with requester 2 granted
    step(8'b00100000, 8'hFF, 1'b0);
    step(8'b00100000, 8'hFF, 1'b0);
    step(8'b00100000, 8'hFF, 1'b0);
    chk("rst_pre_g", G, 8'b00100000);
    chk("rst_pre_f", 8'(f), 8'd1);
    #2;
    Resetn = 1'b0;
    #1;
    m_reset();
    chk_all();
    @(posedge Clock);
    #1;
    chk_all();
    Resetn = 1'b1;
    step(8'b00100100, 8'hFF, 1'b0);
    chk("rst_first_grant", 8'(S), 8'd2);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rr = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      step(rr, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares one 8-to-1 single-bit mux among eight requesters. Each requester i presents a data bit on W[i] and raises R[i]. The block grants one requester at a time, drives the mux select S, and registers the selected bit onto f with a Valid/Ack handshake toward the consumer. A watchdog aborts a transfer that the consumer never acknowledges. The block instantiates the team's mux8to1 internally as its datapath.

## Interface
- TIMEOUT, default 15: WAIT-state cycles allowed before an un-acked transfer aborts. Legal range 1..255; 0 disables the watchdog.
- Clock  input  1  sole clock; all state updates on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- R  input  [0:7]  request lines; R[i] belongs to requester i.
- W  input  [0:7]  data bits; mux input i.
- Ack  input  1  consumer accepts f; sampled only while Valid=1.
- G  output  [0:7]  registered one-hot grant; all zero when idle.
- S  output  [2:0]  registered mux select, equal to the granted index.
- f  output  1  registered sampled data bit.
- Valid  output  1  f holds data from the granted requester.
- Err  output  1  one-cycle pulse when a transfer times out.

## Operation
- State machine: IDLE, SAMPLE, WAIT. An internal 3-bit Ptr holds the highest-priority index.
- **IDLE**
  - Valid=0 and G=0.
  - If any R[i]=1, pick the first set index scanning Ptr, Ptr+1, …, Ptr+7 (mod 8).
  - Register S<=idx and G<=onehot(idx), then go to SAMPLE.
  - If no request is present, stay in IDLE; S keeps its last value.
- **SAMPLE**
  - f<=W[S] through the mux8to1 instance.
  - Valid<=1, clear the watchdog counter, go to WAIT.
- **WAIT**
  - Hold S, G, f and Valid.
  - If Ack=1: Valid<=0, G<=0, Ptr<=S+1 (7 wraps to 0), go to IDLE.
  - Else if TIMEOUT≠0 and count==TIMEOUT-1: Valid<=0, G<=0, Err<=1 for one cycle, Ptr<=S+1, go to IDLE.
  - Else count<=count+1.
- Watchdog counter is 8 bits.
- Only R is sampled in IDLE. Dropping R[i] after the grant does not cancel the transfer. W is sampled only in SAMPLE.
- Err is registered, so it is high exactly one cycle: the cycle after the aborting edge.
- Reset (asynchronous, at any time including mid-transfer): state=IDLE, Ptr=0, S=0, G=0, f=0, Valid=0, Err=0, count=0. The aborted transfer is lost; there is no Err pulse for it.

## Timing
- Request present at edge k in IDLE:
  - G and S valid after edge k.
  - f and Valid high after edge k+1.
- Ack=1 at the first edge where Valid=1: Valid is high one cycle and the block is in IDLE after that edge. The next grant can appear after the following edge.
- Minimum transfer period is 3 cycles per grant under continuous requests and immediate Ack.
- Without Ack, Valid stays high exactly TIMEOUT cycles.
- Ack and timeout at the same edge: Ack wins, Err stays 0.
- Ack while Valid=0 is ignored.
- Fairness: a requester holding R waits at most 7 other transfers before it is granted.

## Test plan
- **Reset**: assert Resetn=0 mid-WAIT with G=8'b00100000. Required: G=0, S=0, f=0, Valid=0 and Err=0 immediately, without a clock edge. The first grant after release goes to the lowest requesting index starting at 0.
- **Single request**: R[5]=1, W[5]=1, Ack held 1. Required: G[5]=1, S=3'd5 after edge 1; Valid=1, f=1 after edge 2; idle after edge 3.
- **Rotation**: R=8'hFF, Ack=1, W=8'b10101010. Required: grant sequence 0,1,…,7,0 at a 3-cycle period, with f matching W[i] each time (1,0,1,0,…).
- **Pointer skip**: grant to 6 completes, then R[2]=R[7]=1. Required: grant 7 first, then 2.
- **Watchdog**: TIMEOUT=3, R[1]=1, Ack=0. Required: Valid high exactly 3 cycles, Err high 1 cycle, and a re-asserted R[1] is granted only after any pending R[2..7,0].
- **Ack/timeout collision**: TIMEOUT=3, Ack=1 on the 3rd WAIT edge. Required: Err stays 0 and Valid drops.
